// File: rtl/traffic_seg_scan_if.sv
// Display-side bundle between the traffic-light controller and the segment scanner.
// Controller drives master (patterns, brightness, enable); the scanner is the slave.
interface traffic_seg_scan_if #(
  parameter int pPWM_BITS = 4
);
  logic                 en;
  logic [6:0]           seg_a;
  logic [6:0]           seg_b;
  logic [pPWM_BITS-1:0] brightness;
  logic [6:0]           seg_out;
  logic [1:0]           dig_sel;
  logic                 frame_done;

  modport master (
    output en, seg_a, seg_b, brightness,
    input  seg_out, dig_sel, frame_done
  );

  modport slave (
    input  en, seg_a, seg_b, brightness,
    output seg_out, dig_sel, frame_done
  );
endinterface

// File: rtl/traffic_seg_scan.sv
// Two-digit 7-segment scanner with dead time and PWM dimming; SEG_SCAN_LZB_EN adds leading-zero blanking.
// Latency: outputs registered, first lit slot appears the cycle after en is seen high.
// Backpressure: none; inputs are sampled once per frame, en=0 drops to IDLE on the next edge.
module traffic_seg_scan #(
  parameter int pREFRESH_CNT_VAL = 249,
  parameter int pDEAD_CNT_VAL    = 9,
  parameter int pPWM_BITS        = 4
) (
  input  logic               clk,
  input  logic               rst,
  traffic_seg_scan_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW_A = 3'd1,
    DEAD_A = 3'd2,
    SHOW_B = 3'd3,
    DEAD_B = 3'd4
  } state_t;

  localparam int MAX_CNT = (pREFRESH_CNT_VAL > pDEAD_CNT_VAL) ? pREFRESH_CNT_VAL : pDEAD_CNT_VAL;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(pREFRESH_CNT_VAL);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((pDEAD_CNT_VAL > 0) ? pDEAD_CNT_VAL - 1 : 0);
  localparam bit HAS_DEAD = (pDEAD_CNT_VAL > 0);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [pPWM_BITS-1:0] pwm_q, pwm_d;
  logic [6:0]           pat_a_q, pat_a_d;
  logic [6:0]           pat_b_q, pat_b_d;
  logic [pPWM_BITS-1:0] bri_q, bri_d;
  logic [6:0]           seg_q, seg_d;
  logic [1:0]           dig_q, dig_d;
  logic                 fd_q, fd_d;
  logic                 latch;
  logic                 lit;

  // Next-state, counters and frame latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    pwm_d   = pwm_q + 1'b1;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = SHOW_A;
        cnt_d   = '0;
        pwm_d   = '0;
        latch   = 1'b1;
      end
      SHOW_A: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          pwm_d   = '0;
          state_d = HAS_DEAD ? DEAD_A : SHOW_B;
        end
      end
      DEAD_A: begin
        if (cnt_q == DEAD_LAST) begin
          cnt_d   = '0;
          pwm_d   = '0;
          state_d = SHOW_B;
        end
      end
      SHOW_B: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          pwm_d = '0;
          if (HAS_DEAD) begin
            state_d = DEAD_B;
          end else begin
            state_d = SHOW_A;
            latch   = 1'b1;
          end
        end
      end
      DEAD_B: begin
        if (cnt_q == DEAD_LAST) begin
          cnt_d   = '0;
          pwm_d   = '0;
          state_d = SHOW_A;
          latch   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      pwm_d   = '0;
      latch   = 1'b0;
    end
    pat_a_d = latch ? bus.seg_a      : pat_a_q;
    pat_b_d = latch ? bus.seg_b      : pat_b_q;
    bri_d   = latch ? bus.brightness : bri_q;
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    seg_d = '0;
    dig_d = '0;
    fd_d  = 1'b0;
    lit   = (pwm_d < bri_d);
    case (state_d)
      SHOW_A: begin
        dig_d = 2'b01;
        seg_d = lit ? pat_a_d : 7'h00;
`ifdef SEG_SCAN_LZB_EN
        if (pat_a_d == 7'h3F) begin
          dig_d = 2'b00;
          seg_d = 7'h00;
        end
`endif
      end
      SHOW_B: begin
        dig_d = 2'b10;
        seg_d = lit ? pat_b_d : 7'h00;
        fd_d  = !HAS_DEAD && (cnt_d == SHOW_LAST);
      end
      DEAD_B: begin
        fd_d = (cnt_d == DEAD_LAST);
      end
      default: begin
        seg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwm_q   <= '0;
      pat_a_q <= '0;
      pat_b_q <= '0;
      bri_q   <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      pat_a_q <= pat_a_d;
      pat_b_q <= pat_b_d;
      bri_q   <= bri_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_traffic_seg_scan.sv
// Bench for traffic_seg_scan: directed scenarios plus random stimulus against a frame-position model.
// Define SEG_SCAN_LZB_EN for both RTL and bench to cover leading-zero blanking.
module tb_traffic_seg_scan;

  localparam int R     = 3;
  localparam int D     = 1;
  localparam int NB    = 2;
  localparam int S     = R + 1;
  localparam int L     = S + D;
  localparam int FRAME = 2 * L;

  logic clk = 1'b0;
  logic rst;

  traffic_seg_scan_if #(.pPWM_BITS(NB)) bus ();

  traffic_seg_scan #(
    .pREFRESH_CNT_VAL (R),
    .pDEAD_CNT_VAL    (D),
    .pPWM_BITS        (NB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: position within the frame plus the values latched at frame start
  bit          m_run = 1'b0;
  int          m_p   = 0;
  logic [6:0]  m_a   = '0;
  logic [6:0]  m_b   = '0;
  int          m_bri = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_latch();
    m_a   = bus.seg_a;
    m_b   = bus.seg_b;
    m_bri = int'(bus.brightness);
  endtask

  task automatic step();
    logic [6:0] e_seg;
    logic [1:0] e_dig;
    logic       e_fd;
    int         half;
    int         off;
    @(posedge clk);
    if (rst || !bus.en) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_p   = 0;
      model_latch();
    end else begin
      m_p = (m_p + 1) % FRAME;
      if (m_p == 0) model_latch();
    end
    e_seg = '0;
    e_dig = '0;
    e_fd  = 1'b0;
    if (m_run) begin
      half = m_p / L;
      off  = m_p % L;
      if (off < S) begin
        e_dig = (half != 0) ? 2'b10 : 2'b01;
        if ((off % (1 << NB)) < m_bri) e_seg = (half != 0) ? m_b : m_a;
`ifdef SEG_SCAN_LZB_EN
        if (half == 0 && m_a == 7'h3F) begin
          e_dig = 2'b00;
          e_seg = 7'h00;
        end
`endif
      end
      e_fd = (m_p == FRAME - 1);
    end
    #1;
    chk("seg_out",    32'(bus.seg_out),    32'(e_seg));
    chk("dig_sel",    32'(bus.dig_sel),    32'(e_dig));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.seg_a      = '0;
    bus.seg_b      = '0;
    bus.brightness = '0;
    repeat (3) step();

    // Basic frame
    rst            = 1'b0;
    bus.en         = 1'b1;
    bus.seg_a      = 7'h06;
    bus.seg_b      = 7'h5B;
    bus.brightness = 2'd3;
    repeat (10) step();

    // seg_b change during SHOW_A must not tear the current frame
    step();
    bus.seg_b = 7'h4F;
    repeat (9) step();
    repeat (10) step();

    // Dark frames still scan and pulse frame_done
    bus.brightness = 2'd0;
    repeat (20) step();

    // Tens digit zero
    bus.seg_a      = 7'h3F;
    bus.brightness = 2'd3;
    repeat (10) step();

    // Disable mid SHOW_B, then restart
    bus.seg_a = 7'h06;
    repeat (7) step();
    bus.en = 1'b0;
    repeat (3) step();
    bus.en = 1'b1;
    repeat (6) step();

    // Reset mid-frame
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (12) step();

    // Random traffic
    repeat (600) begin
      rst            = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 24) == 0) bus.en = ~bus.en;
      bus.seg_a      = ($urandom_range(0, 3) == 0) ? 7'h3F : 7'($urandom);
      bus.seg_b      = 7'($urandom);
      bus.brightness = NB'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
